// File: rtl/xg_wr_arb_pkg.sv
// xg_wr_arb_pkg: shared FSM state type and sizing constants for the FIFO write arbiter
package xg_wr_arb_pkg;
    localparam int NREQ_MAX = 8;
    localparam int PTR_W = $clog2(NREQ_MAX);
    typedef enum logic {IDLE, XFER} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot round-robin pick searching upward from rr_ptr with wrap.
// With XG_WR_ARB_PRIO0_EN defined, requester 0 wins whenever it is valid.
module rr_pick
    import xg_wr_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  winner
);
    always_comb begin
        winner = '0;
        // walk the search order backwards so the nearest valid slot is written last
        for (int k = NREQ - 1; k >= 0; k--)
            for (int i = 0; i < NREQ; i++)
                if (valid[i] && i == (int'(rr_ptr) + k) % NREQ) begin
                    winner = '0;
                    winner[i] = 1'b1;
                end
`ifdef XG_WR_ARB_PRIO0_EN
        if (valid[0]) winner = NREQ'(1);
`endif
    end
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: packet-atomic round-robin arbiter feeding one async FIFO write port.
// Optional XG_WR_ARB_PRIO0_EN (in rr_pick) gives requester 0 absolute priority.
module fifo_wr_arb
    import xg_wr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [DSIZE-1:0]      fifo_wdata,
    output logic                  fifo_winc,
    input  logic                  fifo_wfull,
    input  logic                  fifo_w_almost_full,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);
    state_t state, state_nxt;
    logic [NREQ-1:0] grant_nxt, winner;
    logic [PTR_W-1:0] rr_ptr, rr_nxt, ptr_after;
    logic last;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .winner (winner)
    );

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // grant is all-zero in IDLE, so the datapath is naturally quiet there
    always_comb begin
        req_ready  = '0;
        fifo_wdata = '0;
        fifo_winc  = 1'b0;
        last       = 1'b0;
        ptr_after  = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) begin
                req_ready[i] = ~fifo_wfull;
                fifo_wdata   = req_data[i*DSIZE +: DSIZE];
                fifo_winc    = req_valid[i] & ~fifo_wfull;
                last         = req_last[i];
                ptr_after    = PTR_W'((i + 1) % NREQ);
            end
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        if (state == IDLE && |req_valid && !fifo_w_almost_full) begin
            state_nxt = XFER;
            grant_nxt = winner;
        end else if (state == XFER && fifo_winc && last) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            rr_nxt    = ptr_after;
        end
    end

    assign busy = (state == XFER);
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed and random checks of fifo_wr_arb against a packet-level model
module tb_fifo_wr_arb;
    localparam int N = 4;
    localparam int DW = 8;

    logic            wclk = 1'b0;
    logic            wrst;
    logic [N-1:0]    req_valid, req_last, req_ready, grant;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   fifo_wdata;
    logic            fifo_winc, fifo_wfull, fifo_w_almost_full, busy;

    int cmp = 0;
    int errs = 0;
    int owner = -1;
    int rr = 0;
    int cnt[N];
    int order[$];
    bit was_busy;

    fifo_wr_arb #(.NREQ(N), .DSIZE(DW)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_wdata(fifo_wdata),
        .fifo_winc(fifo_winc), .fifo_wfull(fifo_wfull),
        .fifo_w_almost_full(fifo_w_almost_full), .grant(grant), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v);
`ifdef XG_WR_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // compare every output against what the packet-level model says right now
    task automatic check_outputs();
        logic [N-1:0] g;
        g = (owner >= 0) ? N'(1) << owner : '0;
        chk("grant", 32'(grant), 32'(g));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("req_ready", 32'(req_ready), fifo_wfull ? 32'd0 : 32'(g));
        chk("fifo_winc", 32'(fifo_winc), 32'(owner >= 0 && req_valid[owner] && !fifo_wfull));
        if (owner >= 0) chk("fifo_wdata", 32'(fifo_wdata), 32'(req_data[owner*DW +: DW]));
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic wf, input logic af);
        req_valid = v;
        req_last = l;
        fifo_wfull = wf;
        fifo_w_almost_full = af;
        req_data = $urandom;
        #1;
        check_outputs();
        @(posedge wclk);
        if (owner < 0) begin
            if (v != 0 && !af) owner = pick(v);
        end else if (v[owner] && !wf) begin
            cnt[owner] = cnt[owner] ^ 1;
            if (l[owner]) begin
                rr = (owner + 1) % N;
                owner = -1;
            end
        end
        @(negedge wclk);
    endtask

    task automatic do_reset();
        #1;
        wrst = 1'b1;
        owner = -1;
        rr = 0;
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_winc", 32'(fifo_winc), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        wrst = 1'b1;
        {req_valid, req_last, req_data, fifo_wfull, fifo_w_almost_full} = '0;
        @(negedge wclk);
        #1;
        check_outputs();
        wrst = 1'b0;
        // two single-word packets from requesters 1 and 2
        step(4'b0110, 4'b0110, 0, 0);
        chk("r033_g1", 32'(grant), 32'b0010);
        step(4'b0110, 4'b0110, 0, 0);
        step(4'b0100, 4'b0100, 0, 0);
        chk("r033_g2", 32'(grant), 32'b0100);
        step(4'b0100, 4'b0100, 0, 0);
        step(4'b0000, 4'b0000, 0, 0);
        chk("r033_idle", 32'(grant), 0);
        // pointer now 3: only requester 1 valid, abandon its packet by reset
        step(4'b0010, 4'b0000, 0, 0);
        step(4'b0010, 4'b0000, 0, 0);
        req_valid = 4'b0010;
        do_reset();
        step(4'b1010, 4'b1010, 0, 0);
        chk("r038_rr0", 32'(grant), 32'b0010);
        step(4'b1010, 4'b1010, 0, 0);
        do_reset();
        // almost-full holds off a new packet
        repeat (3) step(4'b1111, 4'b1111, 0, 1);
        chk("r035_hold", 32'(grant), 0);
        step(4'b1111, 4'b1111, 0, 0);
        chk("r035_g0", 32'(grant), 32'b0001);
        step(4'b1111, 4'b1111, 0, 1);
        // 3-word packet from requester 0 with a 2-cycle full stall on word 2
        do_reset();
        step(4'b0001, 4'b0000, 0, 0);
        step(4'b0001, 4'b0000, 0, 0);
        step(4'b0001, 4'b0000, 1, 0);
        step(4'b0001, 4'b0000, 1, 0);
        chk("r034_held", 32'(grant), 32'b0001);
        step(4'b0001, 4'b0000, 0, 1);
        step(4'b0001, 4'b0001, 0, 0);
        chk("r034_done", 32'(grant), 0);
        // continuous 2-word packets from everyone
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        was_busy = 1'b0;
        repeat (15) begin
            logic [N-1:0] l;
            for (int i = 0; i < N; i++) l[i] = (cnt[i] == 1);
            step(4'b1111, l, 0, 0);
            if (busy && !was_busy)
                for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
            was_busy = busy;
        end
        chk("r036_count", 32'(order.size()), 5);
        for (int i = 0; i < 5 && i < order.size(); i++) chk("r036_order", 32'(order[i]), 32'(i % N));
        // pointer at 2 with requesters 0 and 2 valid
        do_reset();
        step(4'b0010, 4'b0010, 0, 0);
        step(4'b0010, 4'b0010, 0, 0);
        step(4'b0101, 4'b0101, 0, 0);
`ifdef XG_WR_ARB_PRIO0_EN
        chk("r037_prio", 32'(grant), 32'b0001);
`else
        chk("r037_rr", 32'(grant), 32'b0100);
`endif
        step(4'b0101, 4'b0101, 0, 0);
        // random traffic
        repeat (400) step(N'($urandom), N'($urandom), ($urandom_range(3) == 0), ($urandom_range(3) == 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
